// File: rtl/useq_ctrl_pkg.sv
// Shared definitions for the useq host controller: command opcodes, FSM states
// and the STATUS byte layout.
package useq_ctrl_pkg;

  localparam logic [7:0] OP_LOAD   = 8'h01;
  localparam logic [7:0] OP_RUN    = 8'h02;
  localparam logic [7:0] OP_HALT   = 8'h03;
  localparam logic [7:0] OP_PUSH   = 8'h04;
  localparam logic [7:0] OP_POP    = 8'h05;
  localparam logic [7:0] OP_STATUS = 8'h06;

  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_RUN_BIT   = 1;

  localparam logic [7:0] POP_OK_BYTE    = 8'h01;
  localparam logic [7:0] POP_EMPTY_BYTE = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_L_ADDR,
    S_L_LEN,
    S_L_DATA,
    S_P_LEN,
    S_P_DATA,
    S_POP_REQ,
    S_POP_WAIT,
    S_RESP
  } state_e;

  function automatic logic [7:0] status_byte(input logic run, input logic empty);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_RUN_BIT]   = run;
    s[STAT_EMPTY_BIT] = empty;
    return s;
  endfunction

endpackage

// File: rtl/useq_ctrl_resp.sv
// Two-byte response shifter: a load presents byte0 the next cycle; byte1 (if any)
// follows the first handshake. Data and valid hold while out_ready_i is low.
module useq_ctrl_resp
  import useq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       two_i,
  input  logic [7:0] byte0_i,
  input  logic [7:0] byte1_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       done_o
);

  logic       valid_q;
  logic       pend_q;
  logic [7:0] data_q;
  logic [7:0] next_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      data_q  <= 8'h00;
      next_q  <= 8'h00;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pend_q  <= two_i;
      data_q  <= byte0_i;
      next_q  <= byte1_i;
    end else if (valid_q && out_ready_i) begin
      if (pend_q) begin
        data_q <= next_q;
        pend_q <= 1'b0;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  // Final byte leaves this cycle: the controller may return to IDLE.
  assign done_o      = valid_q && out_ready_i && !pend_q;

endmodule

// File: rtl/useq_ctrl.sv
// Host command decoder for one useq core: RAM load, run/halt, FIFO push/pop, status.
// Strobes are registered (one cycle after accept); h_in_ready drops while a response waits.
module useq_ctrl
  import useq_ctrl_pkg::*;
#(
  parameter logic       RUN_ON_RESET = 1'b0,
  parameter logic [7:0] ACK_BYTE     = 8'hA5,
  parameter logic [7:0] ERR_BYTE     = 8'hEE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       h_in_valid,
  output logic       h_in_ready,
  input  logic [7:0] h_in_data,
  output logic       h_out_valid,
  input  logic       h_out_ready,
  output logic [7:0] h_out_data,
  output logic       ram_we,
  output logic [7:0] ram_waddr,
  output logic [7:0] ram_wdata,
  output logic       core_rst_n,
  output logic       core_write_fifo,
  output logic       core_read_fifo,
  output logic [7:0] core_fifo_in,
  input  logic [7:0] core_fifo_out,
  input  logic       core_fifo_empty
);

  state_e     state_q;
  logic       run_q;
  logic       ram_we_q;
  logic       wr_q;
  logic [7:0] addr_q;
  logic [7:0] ram_waddr_q;
  logic [7:0] ram_wdata_q;
  logic [7:0] fifo_in_q;
  logic [7:0] rem_q;

  logic       in_acc;
  logic       resp_load;
  logic       resp_two;
  logic [7:0] resp_b0;
  logic [7:0] resp_b1;
  logic       resp_done;

  always_comb begin
    h_in_ready = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_IDLE, S_L_ADDR, S_L_LEN, S_L_DATA, S_P_LEN, S_P_DATA: h_in_ready = 1'b1;
        default:                                                h_in_ready = 1'b0;
      endcase
    end
  end

  assign in_acc = h_in_valid && h_in_ready;

  // Response bytes are decided on the accepting/capturing edge so valid rises the next cycle.
  always_comb begin
    resp_load = 1'b0;
    resp_two  = 1'b0;
    resp_b0   = ACK_BYTE;
    resp_b1   = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (in_acc) begin
          case (h_in_data)
            OP_LOAD, OP_PUSH, OP_POP: resp_load = 1'b0;
            OP_RUN, OP_HALT:          resp_load = 1'b1;
            OP_STATUS: begin
              resp_load = 1'b1;
              resp_b0   = status_byte(run_q, core_fifo_empty);
            end
            default: begin
              resp_load = 1'b1;
              resp_b0   = ERR_BYTE;
            end
          endcase
        end
      end
      S_L_DATA: begin
        if (in_acc && rem_q == 8'h00) resp_load = 1'b1;
      end
      S_P_DATA: begin
        if (in_acc && rem_q == 8'h00) begin
          resp_load = 1'b1;
          resp_b0   = run_q ? ACK_BYTE : ERR_BYTE;
        end
      end
      S_POP_REQ: begin
        if (!run_q) begin
          resp_load = 1'b1;
          resp_two  = 1'b1;
          resp_b0   = ERR_BYTE;
        end else if (core_fifo_empty) begin
          resp_load = 1'b1;
          resp_two  = 1'b1;
          resp_b0   = POP_EMPTY_BYTE;
        end
      end
      S_POP_WAIT: begin
        resp_load = 1'b1;
        resp_two  = 1'b1;
        resp_b0   = POP_OK_BYTE;
        resp_b1   = core_fifo_out;
      end
      default: resp_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      run_q       <= RUN_ON_RESET;
      ram_we_q    <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 8'h00;
      ram_waddr_q <= 8'h00;
      ram_wdata_q <= 8'h00;
      fifo_in_q   <= 8'h00;
      rem_q       <= 8'h00;
    end else begin
      ram_we_q <= 1'b0;
      wr_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_acc) begin
            case (h_in_data)
              OP_LOAD: begin
                run_q   <= 1'b0;
                state_q <= S_L_ADDR;
              end
              OP_RUN: begin
                run_q   <= 1'b1;
                state_q <= S_RESP;
              end
              OP_HALT: begin
                run_q   <= 1'b0;
                state_q <= S_RESP;
              end
              OP_PUSH: state_q <= S_P_LEN;
              OP_POP:  state_q <= S_POP_REQ;
              default: state_q <= S_RESP;
            endcase
          end
        end
        S_L_ADDR: begin
          if (in_acc) begin
            addr_q  <= h_in_data;
            state_q <= S_L_LEN;
          end
        end
        S_L_LEN: begin
          // rem_q counts bytes still to come minus one, so len 0 yields 256.
          if (in_acc) begin
            rem_q   <= h_in_data - 8'd1;
            state_q <= S_L_DATA;
          end
        end
        S_L_DATA: begin
          if (in_acc) begin
            ram_we_q    <= 1'b1;
            ram_waddr_q <= addr_q;
            ram_wdata_q <= h_in_data;
            addr_q      <= addr_q + 8'd1;
            rem_q       <= rem_q - 8'd1;
            if (rem_q == 8'h00) state_q <= S_RESP;
          end
        end
        S_P_LEN: begin
          if (in_acc) begin
            rem_q   <= h_in_data - 8'd1;
            state_q <= S_P_DATA;
          end
        end
        S_P_DATA: begin
          if (in_acc) begin
            wr_q  <= run_q;
            rem_q <= rem_q - 8'd1;
            if (run_q) fifo_in_q <= h_in_data;
            if (rem_q == 8'h00) state_q <= S_RESP;
          end
        end
        S_POP_REQ: state_q <= (run_q && !core_fifo_empty) ? S_POP_WAIT : S_RESP;
        S_POP_WAIT: state_q <= S_RESP;
        S_RESP: begin
          if (resp_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  useq_ctrl_resp u_resp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (resp_load),
    .two_i       (resp_two),
    .byte0_i     (resp_b0),
    .byte1_i     (resp_b1),
    .out_valid_o (h_out_valid),
    .out_ready_i (h_out_ready),
    .out_data_o  (h_out_data),
    .done_o      (resp_done)
  );

  assign ram_we          = ram_we_q;
  assign ram_waddr       = ram_waddr_q;
  assign ram_wdata       = ram_wdata_q;
  assign core_rst_n      = run_q;
  assign core_write_fifo = wr_q;
  assign core_fifo_in    = fifo_in_q;
  assign core_read_fifo  = (state_q == S_POP_REQ) && run_q && !core_fifo_empty;

endmodule

// File: tb/tb_useq_ctrl.sv
// Scoreboard bench for useq_ctrl: a command-level reference model predicts responses,
// RAM writes and FIFO pushes; monitors compare as the DUT emits them.
module tb_useq_ctrl;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] ERR = 8'hEE;
  localparam int         CAP = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       h_in_valid = 1'b0;
  logic       h_in_ready;
  logic [7:0] h_in_data = 8'h00;
  logic       h_out_valid;
  logic       h_out_ready = 1'b0;
  logic [7:0] h_out_data;
  logic       ram_we;
  logic [7:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic       core_rst_n;
  logic       core_write_fifo;
  logic       core_read_fifo;
  logic [7:0] core_fifo_in;
  logic [7:0] env_out = 8'h00;
  logic       env_empty = 1'b1;

  always #5 clk = ~clk;

  useq_ctrl #(.RUN_ON_RESET(1'b0), .ACK_BYTE(ACK), .ERR_BYTE(ERR)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_in_valid(h_in_valid), .h_in_ready(h_in_ready), .h_in_data(h_in_data),
    .h_out_valid(h_out_valid), .h_out_ready(h_out_ready), .h_out_data(h_out_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .core_rst_n(core_rst_n), .core_write_fifo(core_write_fifo), .core_read_fifo(core_read_fifo),
    .core_fifo_in(core_fifo_in), .core_fifo_out(env_out), .core_fifo_empty(env_empty)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] ram_exp[$];
  logic [7:0]  push_exp[$];
  logic [7:0]  dq[$];
  logic [7:0]  ref_fifo[$];
  bit          ref_run = 1'b0;
  logic [7:0]  env_fifo[$];

  bit   rand_rdy = 1'b0;
  logic force_rdy = 1'b1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in for the useq FIFO port: registered pop data, cleared while the core is held in reset.
  always @(posedge clk) begin
    if (core_rst_n === 1'b0) begin
      env_fifo.delete();
    end else begin
      if (core_write_fifo === 1'b1 && env_fifo.size() < CAP) env_fifo.push_back(core_fifo_in);
      if (core_read_fifo === 1'b1 && env_fifo.size() > 0) env_out <= env_fifo.pop_front();
    end
    env_empty <= (env_fifo.size() == 0);
  end

  always @(posedge clk) begin
    #1;
    h_out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("out_hold_valid", 16'(h_out_valid), 16'd1);
        chk("out_hold_data", 16'(h_out_data), 16'(prev_dat));
      end
      if (h_out_valid) begin
        chk("in_ready_during_resp", 16'(h_in_ready), 16'd0);
        if (h_out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_unexpected: got %h expected no byte", h_out_data);
          end else begin
            chk("resp_byte", 16'(h_out_data), 16'(exp_q.pop_front()));
          end
        end
      end
      prev_stall = h_out_valid && !h_out_ready;
      prev_dat   = h_out_data;
    end
    if (ram_we) begin
      if (ram_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL ram_unexpected: got %h<-%h expected no write", ram_waddr, ram_wdata);
      end else begin
        chk("ram_write", {ram_waddr, ram_wdata}, ram_exp.pop_front());
      end
    end
    if (core_write_fifo) begin
      if (push_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL push_unexpected: got %h expected no push", core_fifo_in);
      end else begin
        chk("push_data", 16'(core_fifo_in), 16'(push_exp.pop_front()));
      end
    end
    if (core_write_fifo || core_read_fifo) begin
      chk("strobe_excl", 16'(core_write_fifo & core_read_fifo), 16'd0);
      chk("strobe_core_running", 16'(core_rst_n), 16'd1);
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    h_in_valid = 1'b1;
    h_in_data  = b;
    while (!h_in_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!h_in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: h_in_ready got 0 expected 1");
      h_in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    h_in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || h_out_valid) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_resp_left"}, 16'(exp_q.size()), 16'd0);
    @(posedge clk); #1;
    chk({name, "_ram_left"}, 16'(ram_exp.size()), 16'd0);
    chk({name, "_push_left"}, 16'(push_exp.size()), 16'd0);
  endtask

  function automatic logic [7:0] next_data();
    if (dq.size() > 0) return dq.pop_front();
    return 8'($urandom);
  endfunction

  task automatic c_load(input logic [7:0] addr, input int n);
    logic [7:0] d;
    ref_run = 1'b0;
    ref_fifo.delete();
    exp_q.push_back(ACK);
    send(8'h01); send(addr); send(8'(n));
    for (int i = 0; i < n; i++) begin
      d = next_data();
      ram_exp.push_back({addr + 8'(i), d});
      send(d);
    end
  endtask

  task automatic c_op(input logic [7:0] op);
    case (op)
      8'h02: begin ref_run = 1'b1; exp_q.push_back(ACK); end
      8'h03: begin ref_run = 1'b0; ref_fifo.delete(); exp_q.push_back(ACK); end
      8'h06: exp_q.push_back({6'b0, ref_run, ref_fifo.size() == 0});
      default: exp_q.push_back(ERR);
    endcase
    send(op);
  endtask

  task automatic c_push(input int n);
    logic [7:0] d;
    exp_q.push_back(ref_run ? ACK : ERR);
    send(8'h04); send(8'(n));
    for (int i = 0; i < n; i++) begin
      d = next_data();
      if (ref_run) begin
        push_exp.push_back(d);
        if (ref_fifo.size() < CAP) ref_fifo.push_back(d);
      end
      send(d);
    end
  endtask

  task automatic c_pop();
    if (!ref_run) begin
      exp_q.push_back(ERR); exp_q.push_back(8'h00);
    end else if (ref_fifo.size() == 0) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    end else begin
      exp_q.push_back(8'h01); exp_q.push_back(ref_fifo.pop_front());
    end
    send(8'h05);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 16'(h_in_ready), 16'd0);
    chk("rst_core_rst_n", 16'(core_rst_n), 16'd0);
    chk("rst_out_valid", 16'(h_out_valid), 16'd0);
    chk("rst_ram_we", 16'(ram_we), 16'd0);
    chk("rst_strobes", {14'd0, core_write_fifo, core_read_fifo}, 16'd0);
    chk("rst_ram_bus", {ram_waddr, ram_wdata}, 16'h0000);
    chk("rst_fifo_in_out_data", {core_fifo_in, h_out_data}, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 16'(h_in_ready), 16'd1);
    @(posedge clk); #1;

    rand_rdy = 1'b1;
    dq = '{8'hAA, 8'hBB, 8'hCC};
    c_load(8'h10, 3); wait_done("load3");
    chk("load_core_halted", 16'(core_rst_n), 16'd0);
    c_load(8'hFE, 4); wait_done("load_wrap");
    c_load(8'h40, 256); wait_done("load256");

    c_op(8'h02); wait_done("run");
    chk("run_core_rst_n", 16'(core_rst_n), 16'd1);
    dq = '{8'h11, 8'h22};
    c_push(2); wait_done("push2");
    c_pop(); wait_done("pop1");
    c_pop(); wait_done("pop2");
    c_pop(); wait_done("pop_empty");

    c_op(8'h03); wait_done("halt");
    dq = '{8'h33};
    c_push(1); wait_done("push_halted");
    c_pop(); wait_done("pop_halted");
    c_op(8'h06); wait_done("status_halted");

    // Unknown opcode with the host stalling the response.
    rand_rdy = 1'b0; force_rdy = 1'b0;
    @(posedge clk); #1;
    c_op(8'h7F);
    n = 0;
    while (!h_out_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 16'(h_out_valid), 16'd1);
      chk("stall_data", 16'(h_out_data), 16'(ERR));
    end
    force_rdy = 1'b1;
    wait_done("unknown_op");
    rand_rdy = 1'b1;

    // Reset in the middle of a PUSH payload.
    c_op(8'h02); wait_done("run2");
    exp_q.delete();
    push_exp.push_back(8'h5A); push_exp.push_back(8'h6B);
    send(8'h04); send(8'h04); send(8'h5A); send(8'h6B);
    rst_n = 1'b0;
    ref_run = 1'b0;
    ref_fifo.delete();
    repeat (3) begin
      @(negedge clk);
      chk("midrst_in_ready", 16'(h_in_ready), 16'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_core_rst_n", 16'(core_rst_n), 16'd0);
    chk("midrst_out_valid", 16'(h_out_valid), 16'd0);
    chk("midrst_push_left", 16'(push_exp.size()), 16'd0);
    @(posedge clk); #1;
    c_op(8'h06); wait_done("status_after_rst");

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 7))
        0:       c_load(8'($urandom), int'($urandom_range(1, 6)));
        1:       c_op(8'h02);
        2:       c_op(8'h03);
        3, 4:    c_push(int'($urandom_range(1, 4)));
        5:       c_pop();
        6:       c_op(8'h06);
        default: c_op(8'($urandom_range(7, 255)));
      endcase
      wait_done("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
